// File: rtl/saph_fpu_rr_arb.sv
// saph_fpu_rr_arb: round-robin arbiter sharing one fixed-latency FPU unit among
// PORTS requesters. Grants one request per cycle, registers it as an issue to
// the FPU, and carries the requester index alongside the operation so the
// result can be routed back when it emerges LATENCY cycles later.

module saph_fpu_rr_arb #(
    parameter int PORTS   = 4,
    parameter int LATENCY = 2,
    parameter int WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PORTS-1:0]       req_valid,
    output logic [PORTS-1:0]       req_ready,
    input  logic [PORTS*3-1:0]     req_op,
    input  logic [PORTS*WIDTH-1:0] req_a,
    input  logic [PORTS*WIDTH-1:0] req_b,
    output logic [PORTS-1:0]       res_valid,
    output logic [WIDTH-1:0]       res_data,
    output logic                   fpu_valid,
    output logic [2:0]             fpu_op,
    output logic [WIDTH-1:0]       fpu_a,
    output logic [WIDTH-1:0]       fpu_b,
    input  logic                   fpu_res_valid,
    input  logic [WIDTH-1:0]       fpu_res,
    output logic                   err
);

    localparam int PW = $clog2(PORTS);

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    gnt_idx;
    logic             gnt_any;
    logic [PW-1:0]    iss_tag;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             tag_v [LATENCY];
    logic [PW-1:0]    tag_p [LATENCY];

    // Grant search: first valid port starting at ptr, wrapping past PORTS-1.
    always_comb begin
        int          idx;
        logic [PW-1:0] cand;
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        idx       = 0;
        cand      = '0;
        gnt_idx   = '0;
        gnt_any   = 1'b0;
        req_ready = '0;
        if (!rst) begin
            for (int k = 0; k < PORTS; k++) begin
                idx = int'(ptr) + k;
                if (idx >= PORTS) idx = idx - PORTS;
                cand = PW'(idx);
                if (!gnt_any && req_valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
            if (gnt_any) req_ready[gnt_idx] = 1'b1;
        end
    end

    // Operand mux for the granted port.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (gnt_idx == PW'(i)) begin
                sel_op = req_op[3*i +: 3];
                sel_a  = req_a[WIDTH*i +: WIDTH];
                sel_b  = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    // Round-robin pointer: move just past the granted port, hold otherwise.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update from pre-edge values, independent of block order.
        if (rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_idx == PW'(PORTS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Issue register: strobe for one cycle, payload holds between issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpu_valid <= 1'b0;
            fpu_op    <= '0;
            fpu_a     <= '0;
            fpu_b     <= '0;
            iss_tag   <= '0;
        end else begin
            fpu_valid <= gnt_any;
            if (gnt_any) begin
                fpu_op  <= sel_op;
                fpu_a   <= sel_a;
                fpu_b   <= sel_b;
                iss_tag <= gnt_idx;
            end
        end
    end

    // Tag valid bits track in-flight operations; reset flushes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) tag_v[i] <= 1'b0;
        end else begin
            tag_v[0] <= fpu_valid;
            for (int i = 1; i < LATENCY; i++) tag_v[i] <= tag_v[i-1];
        end
    end

    // Tag port indices shift alongside the valid bits.
    always_ff @(posedge clk) begin
        // NOTE: the index payload is left unreset; it is only consulted when
        // its valid bit is set, and the valid bits are reset.
        tag_p[0] <= iss_tag;
        for (int i = 1; i < LATENCY; i++) tag_p[i] <= tag_p[i-1];
    end

    // Result routing: strobe the tagged port when the FPU result is expected.
    always_comb begin
        res_data  = fpu_res;
        res_valid = '0;
        if (!rst && fpu_res_valid && tag_v[LATENCY-1]) begin
            res_valid[tag_p[LATENCY-1]] = 1'b1;
        end
    end

    // Sticky error when a result and its tag disagree about being present.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (fpu_res_valid != tag_v[LATENCY-1]) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_saph_fpu_rr_arb.sv
// tb_saph_fpu_rr_arb: directed bench for saph_fpu_rr_arb with a small
// fixed-latency FPU model. Inputs change just after the rising edge; outputs
// are checked on the falling edge.

module tb_saph_fpu_rr_arb;

    localparam int PORTS   = 4;
    localparam int LATENCY = 2;
    localparam int WIDTH   = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [PORTS-1:0]       req_valid;
    logic [PORTS-1:0]       req_ready;
    logic [PORTS*3-1:0]     req_op;
    logic [PORTS*WIDTH-1:0] req_a;
    logic [PORTS*WIDTH-1:0] req_b;
    logic [PORTS-1:0]       res_valid;
    logic [WIDTH-1:0]       res_data;
    logic                   fpu_valid;
    logic [2:0]             fpu_op;
    logic [WIDTH-1:0]       fpu_a;
    logic [WIDTH-1:0]       fpu_b;
    logic                   fpu_res_valid;
    logic [WIDTH-1:0]       fpu_res;
    logic                   err;
    logic                   force_rv;

    int n_assert = 0;
    int n_fail   = 0;

    saph_fpu_rr_arb #(.PORTS(PORTS), .LATENCY(LATENCY), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_data(res_data),
        .fpu_valid(fpu_valid), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_res_valid(fpu_res_valid), .fpu_res(fpu_res),
        .err(err)
    );

    always #5 clk = ~clk;

    // Stand-in FPU result: 1.0 + 2.0 gives 3.0, anything else a recognisable mix.
    function automatic logic [31:0] fake(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 3'd1 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a ^ b ^ {29'd0, op};
    endfunction

    // FPU model: fixed LATENCY pipeline, reset by the same rst.
    logic        mv [LATENCY];
    logic [31:0] md [LATENCY];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) mv[i] <= 1'b0;
        end else begin
            mv[0] <= fpu_valid;
            md[0] <= fake(fpu_op, fpu_a, fpu_b);
            for (int i = 1; i < LATENCY; i++) begin
                mv[i] <= mv[i-1];
                md[i] <= md[i-1];
            end
        end
    end
    assign fpu_res_valid = mv[LATENCY-1] | force_rv;
    assign fpu_res       = md[LATENCY-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        req_valid = '0;
        force_rv  = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic set_port(input int p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[3*p +: 3]      = op;
        req_a[WIDTH*p +: WIDTH] = a;
        req_b[WIDTH*p +: WIDTH] = b;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        force_rv  = 1'b0;

        // Reset: requests present but nothing granted.
        req_valid = 4'b1111;
        next_cycle();
        sample();
        check("rst_ready", req_ready, 4'b0000);
        check("rst_res_valid", res_valid, 4'b0000);
        check("rst_fpu_valid", fpu_valid, 1'b0);
        check("rst_fpu_a", fpu_a, 32'h0);
        check("rst_err", err, 1'b0);
        check("rst_ptr", dut.ptr, 2'd0);
        next_cycle();

        // Single request on port 2.
        rst = 1'b0;
        set_port(2, 3'd1, 32'h3F80_0000, 32'h4000_0000);
        req_valid = 4'b0100;
        sample();
        check("single_ready_c0", req_ready, 4'b0100);
        next_cycle();
        req_valid = 4'b0000;
        sample();
        check("single_fpu_valid_c1", fpu_valid, 1'b1);
        check("single_fpu_op_c1", fpu_op, 3'd1);
        check("single_fpu_a_c1", fpu_a, 32'h3F80_0000);
        check("single_fpu_b_c1", fpu_b, 32'h4000_0000);
        check("single_ready_c1", req_ready, 4'b0000);
        next_cycle();
        sample();
        check("single_res_valid_c2", res_valid, 4'b0000);
        next_cycle();
        sample();
        check("single_res_valid_c3", res_valid, 4'b0100);
        check("single_res_data_c3", res_data, 32'h4040_0000);
        next_cycle();
        sample();
        check("single_fpu_valid_c4", fpu_valid, 1'b0);
        check("single_fpu_op_hold_c4", fpu_op, 3'd1);
        check("single_res_valid_c4", res_valid, 4'b0000);
        check("single_err", err, 1'b0);

        // Fairness: all ports valid for six cycles.
        do_reset();
        for (int p = 0; p < PORTS; p++)
            set_port(p, 3'(p + 2), 32'h1111_0000 + 32'(p), 32'h0000_2200 + 32'(p * 16));
        for (int c = 0; c < 9; c++) begin
            req_valid = (c < 6) ? 4'b1111 : 4'b0000;
            sample();
            check($sformatf("fair_ready_c%0d", c), req_ready, (c < 6) ? (4'b0001 << (c % 4)) : 4'b0000);
            if (c >= 1 && c <= 6)
                check($sformatf("fair_fpu_a_c%0d", c), fpu_a, 32'h1111_0000 + 32'((c - 1) % 4));
            if (c >= 3) begin
                check($sformatf("fair_res_valid_c%0d", c), res_valid, 4'b0001 << ((c - 3) % 4));
                check($sformatf("fair_res_data_c%0d", c), res_data,
                      fake(3'(((c - 3) % 4) + 2), 32'h1111_0000 + 32'((c - 3) % 4),
                           32'h0000_2200 + 32'(((c - 3) % 4) * 16)));
            end else begin
                check($sformatf("fair_res_valid_c%0d", c), res_valid, 4'b0000);
            end
            next_cycle();
        end
        req_valid = '0;
        sample();
        check("fair_err", err, 1'b0);

        // Wrap and skip: bring ptr to 3, then only ports 1 and 3 request.
        do_reset();
        req_valid = 4'b0100;
        sample();
        check("wrap_setup_ready", req_ready, 4'b0100);
        next_cycle();
        req_valid = 4'b1010;
        sample();
        check("wrap_ptr_before", dut.ptr, 2'd3);
        check("wrap_ready_port3", req_ready, 4'b1000);
        next_cycle();
        sample();
        check("wrap_ready_port1", req_ready, 4'b0010);
        next_cycle();
        req_valid = 4'b0000;
        sample();
        check("wrap_ptr_after", dut.ptr, 2'd2);
        for (int c = 0; c < 5; c++) next_cycle();
        sample();
        check("wrap_err", err, 1'b0);

        // Reset mid-flight: two grants, then reset before results return.
        do_reset();
        req_valid = 4'b0001;
        sample();
        check("mid_ready_c0", req_ready, 4'b0001);
        next_cycle();
        req_valid = 4'b0010;
        sample();
        check("mid_ready_c1", req_ready, 4'b0010);
        next_cycle();
        rst       = 1'b1;
        req_valid = 4'b0100;
        sample();
        check("mid_ready_in_rst", req_ready, 4'b0000);
        next_cycle();
        rst       = 1'b0;
        req_valid = 4'b0000;
        sample();
        check("mid_res_valid_c3", res_valid, 4'b0000);
        check("mid_fpu_valid_c3", fpu_valid, 1'b0);
        check("mid_ptr_c3", dut.ptr, 2'd0);
        next_cycle();
        sample();
        check("mid_res_valid_c4", res_valid, 4'b0000);
        check("mid_err_c4", err, 1'b0);
        next_cycle();
        sample();
        check("mid_err_c5", err, 1'b0);

        // Protocol error: result strobe with nothing in flight.
        do_reset();
        force_rv = 1'b1;
        sample();
        check("perr_res_valid", res_valid, 4'b0000);
        check("perr_err_same_cycle", err, 1'b0);
        next_cycle();
        force_rv = 1'b0;
        sample();
        check("perr_err_next", err, 1'b1);
        for (int c = 0; c < 4; c++) next_cycle();
        sample();
        check("perr_err_sticky", err, 1'b1);
        do_reset();
        sample();
        check("perr_err_cleared", err, 1'b0);

        // Idle: after one grant to port 1, ten quiet cycles leave ptr at 2.
        req_valid = 4'b0010;
        sample();
        check("idle_setup_ready", req_ready, 4'b0010);
        next_cycle();
        req_valid = 4'b0000;
        next_cycle();
        for (int c = 0; c < 10; c++) begin
            sample();
            check($sformatf("idle_fpu_valid_c%0d", c), fpu_valid, 1'b0);
            check($sformatf("idle_ready_c%0d", c), req_ready, 4'b0000);
            check($sformatf("idle_ptr_c%0d", c), dut.ptr, 2'd2);
            next_cycle();
        end
        sample();
        check("idle_err", err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/saph_fpu_rr_arb.md
SAPH_FPU_RR_ARB -- requirements
Module: saph_fpu_rr_arb

Interface
REQ-001 SHALL have parameter PORTS, default 4: number of requesting ports (2..16).
REQ-002 SHALL have parameter LATENCY, default 2: fixed issue-to-result latency of the attached FPU unit (1..8).
REQ-003 SHALL have parameter WIDTH, default 32: operand and result width.
REQ-004 clk  in  1  core clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 req_valid  in  PORTS  per-port request valid.
REQ-007 req_ready  out  PORTS  per-port grant; one-hot or zero.
REQ-008 req_op  in  PORTS*3  per-port opcode; port i at bits [3i+2:3i].
REQ-009 req_a, req_b  in  PORTS*WIDTH  per-port operands; port i at [WIDTH*i+WIDTH-1:WIDTH*i].
REQ-010 res_valid  out  PORTS  per-port result strobe.
REQ-011 res_data  out  WIDTH  result data, shared by all ports.
REQ-012 fpu_valid  out  1  issue strobe to FPU unit.
REQ-013 fpu_op  out  3; fpu_a, fpu_b  out  WIDTH  issued opcode and operands.
REQ-014 fpu_res_valid  in  1; fpu_res  in  WIDTH  result from FPU unit.
REQ-015 err  out  1  sticky protocol-error flag.

Function
REQ-016 Handshake: a request on port i is accepted in a cycle where req_valid[i] and req_ready[i] are both 1; requesters hold op/operands stable until accepted.
REQ-017 req_ready SHALL be combinational from req_valid and the round-robin pointer ptr; req_ready SHALL never be asserted for a port with req_valid low.
REQ-018 Grant: the first port with req_valid high, searching ptr, ptr+1, ..., PORTS-1, 0, ..., ptr-1 (wrap-around).
REQ-019 On a grant to port g, ptr SHALL become (g+1) mod PORTS next cycle; with no grant, ptr holds.
REQ-020 At most one grant per cycle; the FPU unit never backpressures, so a valid request is granted every cycle at least one req_valid is high.
REQ-021 Issue register: the cycle after acceptance at T, fpu_valid=1 with the accepted op/a/b (cycle T+1); otherwise fpu_valid=0 and fpu_op/fpu_a/fpu_b hold their last values.
REQ-022 Tag pipeline: LATENCY-stage shift register of {valid, port index (ceil(log2 PORTS) bits)} loaded from the issue register, advancing every cycle.
REQ-023 Result routing: fpu_res_valid is expected at T+1+LATENCY; in that cycle res_valid[tag]=1 combinationally, all other res_valid bits 0.
REQ-024 res_data SHALL equal fpu_res combinationally at all times.
REQ-025 Total latency: acceptance at cycle T gives res_valid at cycle T+1+LATENCY; throughput one operation per cycle.
REQ-026 Mismatch: fpu_res_valid high with tag-valid low, or tag-valid high with fpu_res_valid low, sets err=1 next cycle; no res_valid is produced for an untagged result.
REQ-027 err is sticky until reset.
REQ-028 Simultaneous events: acceptance, issue, and result routing in the same cycle are independent and SHALL all take effect.

Reset
REQ-029 While rst is high: req_ready=0, res_valid=0, no acceptance.
REQ-030 On rst: ptr=0, fpu_valid=0, fpu_op/fpu_a/fpu_b=0, all tag-valid bits=0, err=0.
REQ-031 Reset mid-operation discards all in-flight tags; results from operations issued before reset never raise res_valid. The attached FPU unit is reset by the same rst, so no err is flagged.

Verification
REQ-032 Single request: PORTS=4, LATENCY=2; port 2 valid at cycle 0 with op=1, a=0x3F800000, b=0x40000000 -> req_ready=0100 at cycle 0; fpu_valid with those values at cycle 1; model returns 0x40400000 at cycle 3 -> res_valid=0100, res_data=0x40400000 at cycle 3.
REQ-033 Fairness: all 4 ports continuously valid from cycle 0 after reset -> grants 0,1,2,3,0,1 on cycles 0..5; res_valid follows the same order on cycles 3..8.
REQ-034 Wrap and skip: ptr=3, only ports 1 and 3 valid -> port 3 granted; next cycle port 1 granted; ptr then equals 2.
REQ-035 Reset mid-flight: grants at cycles 0 and 1, rst high at cycle 2 -> no res_valid at cycles 3-4, err=0, ptr=0 after reset.
REQ-036 Protocol error: fpu_res_valid forced high with no operation in flight -> res_valid=0 that cycle, err=1 the next cycle and stays 1 until rst.
REQ-037 Idle: req_valid=0 for 10 cycles -> fpu_valid=0, req_ready=0, ptr unchanged throughout.
